stopwatch_ctrl: RTL

Sequencing controller for the stopwatch timer datapath. Takes single-cycle key-edge pulses from the key/debouncer front end and the 10 ms tick from the timer prescaler. Drives the timer's run, direction, clear and load controls, and selects what value the seven-segment scan logic shows (live, lap or zero). Also generates the countdown-expiry alarm and the pause blink.

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/stopwatch_ctrl_blink_gen.sv | 43 ++++
 rtl/stopwatch_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch controller slice.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_LAP   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int unsigned PRESET_DEF      = 6000;
  localparam int unsigned UP_LIMIT_DEF    = 359999;
  localparam int unsigned ALARM_TICKS_DEF = 300;
  localparam int unsigned BLINK_TICKS_DEF = 25;

endpackage

// File: rtl/stopwatch_ctrl_blink_gen.sv
// Tick-qualified blinker: restarts at INIT on activation, toggles every BLINK_TICKS ticks, 0 when inactive.
module blink_gen #(
  parameter int unsigned BLINK_TICKS = 25,
  parameter bit          INIT        = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic tick,
  output logic level
);

  localparam int unsigned CW = $clog2(BLINK_TICKS + 1);

  logic [CW-1:0] cnt;
  logic          active_q;

  // active is the next-cycle view, so the level is correct in the same cycle as the state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      level    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      active_q <= active;
      if (!active) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (!active_q) begin
        cnt   <= '0;
        level <= INIT;
      end else if (tick) begin
        if (cnt == CW'(BLINK_TICKS - 1)) begin
          cnt   <= '0;
          level <= ~level;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: key pulses and 10 ms tick drive timer controls, display select and alarm.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned W           = 32,
  parameter int unsigned PRESET      = PRESET_DEF,
  parameter int unsigned UP_LIMIT    = UP_LIMIT_DEF,
  parameter int unsigned ALARM_TICKS = ALARM_TICKS_DEF,
  parameter int unsigned BLINK_TICKS = BLINK_TICKS_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_start_pulse,
  input  logic         io_lap_pulse,
  input  logic         io_mode_pulse,
  input  logic         io_tick,
  input  logic [W-1:0] io_time,
  output logic         io_timer_run,
  output logic         io_timer_up,
  output logic         io_timer_clear,
  output logic         io_timer_load,
  output logic [W-1:0] io_load_value,
  output logic [W-1:0] io_disp_value,
  output logic         io_disp_blank,
  output logic         io_alarm,
  output logic [2:0]   io_state
);

  localparam int unsigned AW = $clog2(ALARM_TICKS + 1);

  state_t         state, state_d;
  logic           up_d, clear_d, load_d, run_d, armed, armed_d, hit;
  logic [W-1:0]   lap_reg, lap_d, disp_d;
  logic [AW-1:0]  alarm_cnt, alarm_cnt_d;

  assign io_load_value = W'(PRESET);
  assign io_state      = state;

  // armed masks the stale io_time during the first RUN cycle, before clear/load reaches the timer
  assign hit = io_tick && armed &&
               (io_timer_up ? (io_time >= W'(UP_LIMIT)) : (io_time == '0));

  always_comb begin
    state_d     = state;
    up_d        = io_timer_up;
    clear_d     = 1'b0;
    load_d      = 1'b0;
    armed_d     = 1'b1;
    lap_d       = lap_reg;
    alarm_cnt_d = alarm_cnt;
    case (state)
      S_IDLE: begin
        if (io_start_pulse) begin
          state_d = S_RUN;
          armed_d = 1'b0;
          if (io_timer_up) clear_d = 1'b1;
          else             load_d  = 1'b1;
        end else if (io_mode_pulse) begin
          up_d = ~io_timer_up;
        end
      end
      S_RUN, S_LAP: begin
        if (io_start_pulse) begin
          state_d = S_PAUSE;
        end else if (io_lap_pulse) begin
          if (state == S_RUN) begin
            state_d = S_LAP;
            lap_d   = io_time;
          end else begin
            state_d = S_RUN;
          end
        end else if (hit) begin
          state_d = io_timer_up ? S_PAUSE : S_DONE;
        end
      end
      S_PAUSE: begin
        if (io_start_pulse) begin
          state_d = S_RUN;
        end else if (io_lap_pulse) begin
          state_d = S_IDLE;
          clear_d = 1'b1;
        end
      end
      S_DONE: begin
        if (io_start_pulse || io_lap_pulse || io_mode_pulse) begin
          state_d = S_IDLE;
        end else if (io_tick) begin
          if (alarm_cnt == AW'(ALARM_TICKS - 1)) state_d = S_IDLE;
          else                                   alarm_cnt_d = alarm_cnt + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != S_DONE) alarm_cnt_d = '0;
    run_d  = (state_d == S_RUN) || (state_d == S_LAP);
    disp_d = (state_d == S_LAP)  ? lap_d :
             (state_d == S_DONE) ? '0    : io_time;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      io_timer_up    <= 1'b1;
      io_timer_run   <= 1'b0;
      io_timer_clear <= 1'b0;
      io_timer_load  <= 1'b0;
      io_disp_value  <= '0;
      lap_reg        <= '0;
      armed          <= 1'b0;
      alarm_cnt      <= '0;
    end else begin
      state          <= state_d;
      io_timer_up    <= up_d;
      io_timer_run   <= run_d;
      io_timer_clear <= clear_d;
      io_timer_load  <= load_d;
      io_disp_value  <= disp_d;
      lap_reg        <= lap_d;
      armed          <= armed_d;
      alarm_cnt      <= alarm_cnt_d;
    end
  end

  blink_gen #(.BLINK_TICKS(BLINK_TICKS), .INIT(1'b0)) u_pause_blink (
    .clock (clock),
    .reset (reset),
    .active(state_d == S_PAUSE),
    .tick  (io_tick),
    .level (io_disp_blank)
  );

  blink_gen #(.BLINK_TICKS(BLINK_TICKS), .INIT(1'b1)) u_alarm_blink (
    .clock (clock),
    .reset (reset),
    .active(state_d == S_DONE),
    .tick  (io_tick),
    .level (io_alarm)
  );

endmodule
